briski_prog_loader: RTL and testbench

BRISKI_PROG_LOADER -- requirements
Module: briski_prog_loader

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/briski_prog_loader_byte_packer.sv | 38 +++
 rtl/briski_prog_loader.sv | 119 +++++++++++
 tb/tb_briski_prog_loader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared BRISKI core definitions: BRAM geometry, boot address and program-loader types.
package riscv_pkg;

  localparam int BRISKI_MEM_DEPTH = 4096;
  localparam int NB_COL           = 4;
  localparam int COL_WIDTH        = 8;
  localparam int ADDR_WIDTH       = $clog2(BRISKI_MEM_DEPTH);
  localparam int STARTUP_ADDR     = 0;

  // Length header and every program word are sent as this many bytes, little-endian.
  localparam int LOADER_HDR_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    FINISH,
    ERR
  } loader_state_t;

endpackage

// File: rtl/briski_prog_loader_byte_packer.sv
// Collects little-endian bytes into 32-bit words; word_valid marks the handshake of the last byte.
module briski_byte_packer
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  byte_cnt;
  logic [31:0] shreg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      byte_cnt <= 2'd0;
      shreg    <= '0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
    end else if (byte_valid) begin
      byte_cnt <= byte_cnt + 2'd1;
      shreg[byte_cnt*COL_WIDTH +: COL_WIDTH] <= byte_data;
    end
  end

  // The completed word includes the byte being accepted this cycle, so the
  // consumer can register it on the same edge as the final handshake.
  always_comb begin
    word = shreg;
    word[byte_cnt*COL_WIDTH +: COL_WIDTH] = byte_data;
  end

  assign word_valid = byte_valid && (byte_cnt == 2'(LOADER_HDR_BYTES - 1));

endmodule

// File: rtl/briski_prog_loader.sv
// Streams a length-prefixed program into instruction BRAM while holding the core in reset.
module briski_prog_loader #(
  parameter int ADDR_WIDTH = $clog2(riscv_pkg::BRISKI_MEM_DEPTH),
  parameter int MEM_WORDS  = riscv_pkg::BRISKI_MEM_DEPTH,
  parameter int BASE_ADDR  = riscv_pkg::STARTUP_ADDR
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic [riscv_pkg::NB_COL-1:0]  mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [31:0]                   mem_wdata,
  output logic                          core_hold,
  output logic                          done,
  output logic                          err
);

  import riscv_pkg::*;

  localparam logic [31:0]           LIMIT = 32'(MEM_WORDS - BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);

  loader_state_t         state_q, state_d;
  logic [ADDR_WIDTH:0]   word_cnt_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic                  core_hold_q;
  logic                  done_q;
  logic [NB_COL-1:0]     mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]           mem_wdata_q;
  logic                  clear;
  logic                  accept;
  logic [31:0]           word;
  logic                  word_valid;

  assign in_ready = (state_q == LEN) || (state_q == DATA);
  assign accept   = in_valid && in_ready;

  briski_byte_packer u_packer (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (clear),
    .byte_valid (accept),
    .byte_data  (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    case (state_q)
      IDLE, ERR: begin
        if (start) begin
          state_d = LEN;
          clear   = 1'b1;
        end
      end
      LEN: begin
        if (word_valid) begin
          if (word == 32'd0)     state_d = FINISH;
          else if (word > LIMIT) state_d = ERR;
          else                   state_d = DATA;
        end
      end
      DATA: begin
        if (word_valid) state_d = WRITE;
      end
      WRITE: begin
        if (word_cnt_q + 1'b1 == len_q) state_d = FINISH;
        else                            state_d = DATA;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      len_q       <= '0;
      core_hold_q <= 1'b0;
      done_q      <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= (state_q == FINISH);
      mem_we_q <= (state_d == WRITE) ? {NB_COL{1'b1}} : '0;

      if (state_q == LEN && word_valid) len_q <= word[ADDR_WIDTH:0];

      // Address and data are captured on the last byte so the write lands in the very next cycle.
      if (state_q == DATA && word_valid) begin
        mem_addr_q  <= BASE + word_cnt_q[ADDR_WIDTH-1:0];
        mem_wdata_q <= word;
      end

      if (clear)                 word_cnt_q <= '0;
      else if (state_q == WRITE) word_cnt_q <= word_cnt_q + 1'b1;

      if (clear)                                        core_hold_q <= 1'b1;
      else if (state_q == FINISH || state_d == ERR)     core_hold_q <= 1'b0;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign core_hold = core_hold_q;
  assign done      = done_q;
  assign err       = (state_q == ERR);

endmodule

// File: tb/tb_briski_prog_loader.sv
// Directed bench for briski_prog_loader on a 16-word BRAM starting at address 0.
module tb_briski_prog_loader;

  localparam int AW    = 4;
  localparam int WORDS = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_hold;
  logic          done;
  logic          err;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem_model [0:WORDS-1];
  int          wr_count = 0;
  int          done_count = 0;
  int          last_addr = -1;

  briski_prog_loader #(
    .ADDR_WIDTH (AW),
    .MEM_WORDS  (WORDS),
    .BASE_ADDR  (0)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_hold (core_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we != 4'h0) begin
      mem_model[mem_addr] <= mem_wdata;
      last_addr <= int'(mem_addr);
      wr_count  <= wr_count + 1;
    end
    if (done) done_count <= done_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("byte_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_data = 8'hXX;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 0; i < 4; i++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
      send_byte(w[8*i +: 8]);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int wc0, dc0;

    // Reset values
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_mem_we", {28'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {28'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_hold_done_err", {29'd0, core_hold, done, err}, 32'd0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1;

    // Basic two-word load
    dc0 = done_count;
    pulse_start();
    check("basic_hold_set", {31'd0, core_hold}, 32'd1);
    check("basic_ready_len", {31'd0, in_ready}, 32'd1);
    send_word(32'd2, 0);
    send_word(32'h0000_0013, 0);
    check("basic_we0", {28'd0, mem_we}, 32'h0000_000F);
    check("basic_addr0", {28'd0, mem_addr}, 32'd0);
    check("basic_data0", mem_wdata, 32'h0000_0013);
    send_word(32'h0010_0093, 0);
    check("basic_we1", {28'd0, mem_we}, 32'h0000_000F);
    check("basic_addr1", {28'd0, mem_addr}, 32'd1);
    check("basic_data1", mem_wdata, 32'h0010_0093);
    check("basic_ready_write", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("basic_finish_done", {30'd0, done, core_hold}, 32'd1);
    check("basic_finish_we", {28'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    check("basic_done_hold", {30'd0, done, core_hold}, 32'd2);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    check("basic_done_once", done_count - dc0, 32'd1);
    check("basic_wr_count", wr_count, 32'd2);
    check("basic_mem0", mem_model[0], 32'h0000_0013);
    check("basic_mem1", mem_model[1], 32'h0010_0093);

    // Empty program
    wc0 = wr_count;
    pulse_start();
    send_word(32'd0, 0);
    check("empty_t1_done", {30'd0, done, core_hold}, 32'd1);
    @(posedge clk); #1;
    check("empty_t2_done", {30'd0, done, core_hold}, 32'd2);
    check("empty_err", {31'd0, err}, 32'd0);
    check("empty_no_write", wr_count - wc0, 32'd0);

    // Overflow: N = MEM_WORDS+1
    wc0 = wr_count;
    pulse_start();
    send_word(32'd17, 0);
    check("ovf_err", {31'd0, err}, 32'd1);
    check("ovf_hold", {31'd0, core_hold}, 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h77;
    repeat (4) @(posedge clk);
    #1;
    check("ovf_ready", {31'd0, in_ready}, 32'd0);
    check("ovf_err_sticky", {31'd0, err}, 32'd1);
    check("ovf_no_write", wr_count - wc0, 32'd0);
    in_valid = 1'b0;
    pulse_start();
    check("ovf_restart_err", {31'd0, err}, 32'd0);
    check("ovf_restart_hold", {31'd0, core_hold}, 32'd1);

    // Stalled stream continuing the restarted load
    wc0 = wr_count;
    send_word(32'd2, 3);
    send_word(32'hDEAD_BEEF, 3);
    check("stall_we0", {28'd0, mem_we}, 32'h0000_000F);
    in_valid = 1'b1;
    in_data  = 8'h0D;
    #1;
    check("stall_ready_write", {31'd0, in_ready}, 32'd0);
    send_byte(8'h0D);
    send_byte(8'hF0);
    repeat (2) begin @(posedge clk); #1; end
    send_byte(8'hFE);
    send_byte(8'hCA);
    wait_done("stall_done");
    check("stall_wr_count", wr_count - wc0, 32'd2);
    check("stall_mem0", mem_model[0], 32'hDEAD_BEEF);
    check("stall_mem1", mem_model[1], 32'hCAFE_F00D);

    // Reset in the middle of an 8-word load
    @(posedge clk); #1;
    wc0 = wr_count;
    pulse_start();
    send_word(32'd8, 0);
    send_word(32'h1111_0000, 0);
    send_word(32'h1111_0001, 0);
    send_word(32'h1111_0002, 0);
    check("midrst_we_before", {28'd0, mem_we}, 32'h0000_000F);
    #2 resetn = 1'b0;
    #1;
    check("midrst_we", {28'd0, mem_we}, 32'd0);
    check("midrst_addr_data", {mem_wdata[27:0], mem_addr}, 32'd0);
    check("midrst_ready_hold", {30'd0, in_ready, core_hold}, 32'd0);
    check("midrst_done_err", {30'd0, done, err}, 32'd0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    check("midrst_partial_writes", wr_count - wc0, 32'd2);
    pulse_start();
    send_word(32'd1, 0);
    send_word(32'h1234_5678, 0);
    wait_done("midrst_fresh_done");
    check("midrst_fresh_mem0", mem_model[0], 32'h1234_5678);

    // Full-depth load
    @(posedge clk); #1;
    wc0 = wr_count;
    pulse_start();
    send_word(32'd16, 0);
    for (int i = 0; i < WORDS; i++) send_word(32'hA500_0000 | i, 0);
    wait_done("full_done");
    check("full_wr_count", wr_count - wc0, 32'd16);
    check("full_last_addr", last_addr, 32'd15);
    check("full_addr_hold", {28'd0, mem_addr}, 32'd15);
    check("full_mem0", mem_model[0], 32'hA500_0000);
    check("full_mem15", mem_model[15], 32'hA500_000F);
    check("full_err", {31'd0, err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
